// File: rtl/cpu_pkg.sv
// Shared opcode encodings and flag bit positions for the accumulator CPU.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_MAB  = 4'h3;
  localparam logic [3:0] OP_MBA  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_CMP  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_JEQ  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result, Z/N/C and a flag write-enable for the decoded opcode.
// Zero latency, no backpressure.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LIT_W  = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [LIT_W-1:0]  lit,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              n,
  output logic              c,
  output logic              flag_we
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] lit_ext;

  // Extra top bit holds carry-out for ADD and borrow for SUB/CMP.
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign lit_ext = DATA_W'(lit);

  always_comb begin
    result  = '0;
    c       = 1'b0;
    flag_we = 1'b0;
    case (op)
      OP_LDA, OP_LDB: result = lit_ext;
      OP_MAB:         result = b;
      OP_MBA:         result = a;
      OP_ADD: begin
        result  = sum[DATA_W-1:0];
        c       = sum[DATA_W];
        flag_we = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        result  = diff[DATA_W-1:0];
        c       = diff[DATA_W];
        flag_we = 1'b1;
      end
      OP_AND: begin
        result  = a & b;
        flag_we = 1'b1;
      end
      OP_OR: begin
        result  = a | b;
        flag_we = 1'b1;
      end
      OP_XOR: begin
        result  = a ^ b;
        flag_we = 1'b1;
      end
      OP_SHL: begin
        result  = {a[DATA_W-2:0], 1'b0};
        c       = a[DATA_W-1];
        flag_we = 1'b1;
      end
      OP_SHR: begin
        result  = {1'b0, a[DATA_W-1:1]};
        c       = a[0];
        flag_we = 1'b1;
      end
      default: result = '0;
    endcase
  end

  assign z = (result == '0);
  assign n = result[DATA_W-1];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle accumulator CPU with external fetch port, Z/N/C flags, jumps and sticky HALT.
// One instruction per clk, no backpressure; fetched word is consumed in the same cycle.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 4,
  parameter int LIT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [LIT_W+3:0]    imem_data,
  output logic [DATA_W-1:0]   alu_out_bus,
  output logic [DATA_W-1:0]   reg_a,
  output logic [DATA_W-1:0]   reg_b,
  output logic [2:0]          flags,
  output logic                halted
);

  localparam int INSTR_W = 4 + LIT_W;

  logic [PC_W-1:0]   pc_q;
  logic [PC_W-1:0]   pc_next;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [2:0]        flags_q;
  logic [2:0]        flags_d;
  logic              halted_q;

  logic [3:0]        op;
  logic [LIT_W-1:0]  lit;
  logic [DATA_W-1:0] alu_result;
  logic              alu_z;
  logic              alu_n;
  logic              alu_c;
  logic              flag_we;
  logic              a_we;
  logic              b_we;

  assign op  = imem_data[INSTR_W-1:LIT_W];
  assign lit = imem_data[LIT_W-1:0];

  cpu_alu #(
    .DATA_W (DATA_W),
    .LIT_W  (LIT_W)
  ) u_alu (
    .a       (a_q),
    .b       (b_q),
    .lit     (lit),
    .op      (op),
    .result  (alu_result),
    .z       (alu_z),
    .n       (alu_n),
    .c       (alu_c),
    .flag_we (flag_we)
  );

  always_comb begin
    a_we = 1'b0;
    b_we = 1'b0;
    case (op)
      OP_LDA, OP_MAB, OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_XOR, OP_SHL, OP_SHR: a_we = 1'b1;
      OP_LDB, OP_MBA:                b_we = 1'b1;
      default: begin
        a_we = 1'b0;
        b_we = 1'b0;
      end
    endcase
  end

  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_Z] = alu_z;
    flags_d[FLAG_N] = alu_n;
    flags_d[FLAG_C] = alu_c;
  end

  // JEQ looks at the flags registered by earlier instructions, not this cycle's ALU.
  always_comb begin
    pc_next = pc_q + PC_W'(1);
    if (op == OP_JMP || (op == OP_JEQ && flags_q[FLAG_Z]))
      pc_next = lit[PC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      flags_q  <= '0;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      if (a_we)    a_q     <= alu_result;
      if (b_we)    b_q     <= alu_result;
      if (flag_we) flags_q <= flags_d;
      if (op == OP_HALT) halted_q <= 1'b1;
      else               pc_q     <= pc_next;
    end
  end

  assign imem_addr   = pc_q;
  assign alu_out_bus = alu_result;
  assign reg_a       = a_q;
  assign reg_b       = b_q;
  assign flags       = flags_q;
  assign halted      = halted_q;

endmodule
